// File: rtl/line_fetch_ctrl.sv
// Scanline fetch controller: reads one video line per request from SDRAM using Avalon-MM bursts,
// buffers the returning words in a skid FIFO and streams them to the scanline buffer.
module line_fetch_ctrl #(
    parameter int unsigned LINE_PIX = 640,
    parameter int unsigned LINES    = 480,
    parameter int unsigned ADDR_W   = 22,
    parameter int unsigned BURST    = 16
) (
    input  logic                   iCLK,
    input  logic                   iRESET,
    input  logic [ADDR_W-1:0]      iFRAME_BASE,
    input  logic [ADDR_W-1:0]      iLINE_STRIDE,
    input  logic                   iFRAME_START,
    input  logic                   iLINE_REQ,
    output logic [ADDR_W-1:0]      oAV_ADDRESS,
    output logic                   oAV_READ,
    output logic [$clog2(BURST):0] oAV_BURSTCOUNT,
    input  logic                   iAV_WAITREQUEST,
    input  logic [15:0]            iAV_READDATA,
    input  logic                   iAV_READDATAVALID,
    output logic [14:0]            oPIX_RGB,
    output logic                   oPIX_WRITE,
    output logic                   oPIX_START,
    input  logic                   iPIX_FULL,
    output logic                   oBUSY,
    output logic                   oFRAME_DONE,
    output logic                   oOVERRUN
);
    localparam int unsigned DEPTH = 2 * BURST;
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CNTW  = PW + 1;
    localparam int unsigned BCW   = $clog2(BURST) + 1;
    localparam int unsigned CW    = 12;
    localparam logic [CW-1:0] LinePixC = CW'(LINE_PIX);
    localparam logic [CW-1:0] LastPixC = CW'(LINE_PIX - 1);
    localparam logic [CW-1:0] LinesC   = CW'(LINES);
    localparam logic [CW-1:0] BurstC   = CW'(BURST);
    localparam logic [CW-1:0] DepthC   = CW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StSol, StFetch, StDrain} state_e;
    state_e state_q, state_d;

    logic [ADDR_W-1:0] stride_q, row_q, av_addr_q;
    logic [CW-1:0]     line_q, req_q, wr_q, out_q, out_d, rem, len, acc_len;
    logic [CNTW-1:0]   cnt_q;
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [14:0]       mem_q [DEPTH];
    logic [14:0]       pix_rgb_q;
    logic [BCW-1:0]    av_bc_q;
    logic av_read_q, pix_write_q, pix_start_q, frame_done_q, overrun_q, pend_q;
    logic accept, issue, push, pop, line_done, busy, req_hold;
    logic unused_msb;

    assign unused_msb = iAV_READDATA[15];

    always_comb begin
        busy      = (state_q != StIdle);
        accept    = av_read_q && !iAV_WAITREQUEST;
        acc_len   = accept ? CW'(av_bc_q) : '0;
        out_d     = out_q + acc_len - CW'(iAV_READDATAVALID);
        req_hold  = av_read_q && !accept;
        rem       = LinePixC - req_q;
        len       = (rem > BurstC) ? BurstC : rem;
        // Reserve FIFO space for every word already in flight plus the new burst.
        issue     = (state_q == StFetch) && !iFRAME_START && !av_read_q && (rem != '0)
                    && ((CW'(cnt_q) + out_q + len) <= DepthC);
        push      = (state_q == StFetch) && !iFRAME_START && iAV_READDATAVALID;
        pop       = (state_q == StFetch) && !iFRAME_START && (cnt_q != '0) && !iPIX_FULL;
        line_done = (state_q == StFetch) && pix_write_q && (wr_q == LastPixC);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (iLINE_REQ && !frame_done_q && (line_q < LinesC)) state_d = StSol;
            StSol:   state_d = StFetch;
            StFetch: if (line_done) state_d = StIdle;
            StDrain: if ((out_d == '0) && !req_hold) state_d = pend_q ? StSol : StIdle;
            default: state_d = StIdle;
        endcase
        // A frame start overrides everything; reads still on the bus must be drained first.
        if (iFRAME_START) begin
            if (((state_q == StFetch) || (state_q == StDrain)) && ((out_d != '0) || req_hold)) begin
                state_d = StDrain;
            end else if (iLINE_REQ) begin
                state_d = StSol;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_ff @(posedge iCLK) begin
        if (push) mem_q[wptr_q] <= iAV_READDATA[14:0];
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            stride_q     <= '0;
            row_q        <= '0;
            av_addr_q    <= '0;
            av_bc_q      <= '0;
            av_read_q    <= 1'b0;
            line_q       <= '0;
            req_q        <= '0;
            wr_q         <= '0;
            out_q        <= '0;
            cnt_q        <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            pix_rgb_q    <= '0;
            pix_write_q  <= 1'b0;
            pix_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            pend_q       <= 1'b0;
        end else begin
            out_q       <= out_d;
            pix_start_q <= (state_d == StSol);
            pix_write_q <= pop;
            if (pop) pix_rgb_q <= mem_q[rptr_q];
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop) rptr_q <= rptr_q + PW'(1);
            cnt_q <= cnt_q + CNTW'(push) - CNTW'(pop);

            if (accept) begin
                av_read_q <= 1'b0;
                req_q     <= req_q + acc_len;
            end else if (issue) begin
                av_read_q <= 1'b1;
                av_addr_q <= row_q + ADDR_W'(req_q);
                av_bc_q   <= len[BCW-1:0];
            end

            if (pix_write_q && (state_q == StFetch)) wr_q <= wr_q + CW'(1);
            if (state_q == StSol) begin
                req_q <= '0;
                wr_q  <= '0;
            end

            if (line_done) begin
                line_q <= line_q + CW'(1);
                row_q  <= row_q + stride_q;
                if ((line_q + CW'(1)) == LinesC) frame_done_q <= 1'b1;
            end

            if (iLINE_REQ && busy && !iFRAME_START) overrun_q <= 1'b1;

            if (iFRAME_START) begin
                stride_q     <= iLINE_STRIDE;
                row_q        <= iFRAME_BASE;
                line_q       <= '0;
                frame_done_q <= 1'b0;
                overrun_q    <= 1'b0;
                cnt_q        <= '0;
                wptr_q       <= '0;
                rptr_q       <= '0;
                pend_q       <= iLINE_REQ;
            end
        end
    end

    assign oAV_ADDRESS    = av_addr_q;
    assign oAV_READ       = av_read_q;
    assign oAV_BURSTCOUNT = av_bc_q;
    assign oPIX_RGB       = pix_rgb_q;
    assign oPIX_WRITE     = pix_write_q;
    assign oPIX_START     = pix_start_q;
    assign oBUSY          = busy;
    assign oFRAME_DONE    = frame_done_q;
    assign oOVERRUN       = overrun_q;
endmodule

// File: tb/tb_line_fetch_ctrl.sv
// Bench for line_fetch_ctrl: randomised Avalon slave and scanline sink, checked against a
// per-line model of expected bursts and pixel words.
module tb_line_fetch_ctrl;
    localparam int LP = 40;
    localparam int NL = 3;
    localparam int AW = 22;
    localparam int BU = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          iRESET = 1'b1;
    logic [AW-1:0] iFRAME_BASE = '0, iLINE_STRIDE = '0;
    logic          iFRAME_START = 1'b0, iLINE_REQ = 1'b0;
    logic          iAV_WAITREQUEST = 1'b0, iAV_READDATAVALID = 1'b0;
    logic [15:0]   iAV_READDATA = '0;
    logic          iPIX_FULL = 1'b0;
    logic [AW-1:0] oAV_ADDRESS;
    logic          oAV_READ, oPIX_WRITE, oPIX_START, oBUSY, oFRAME_DONE, oOVERRUN;
    logic [4:0]    oAV_BURSTCOUNT;
    logic [14:0]   oPIX_RGB;

    line_fetch_ctrl #(.LINE_PIX(LP), .LINES(NL), .ADDR_W(AW), .BURST(BU)) dut (
        .iCLK(clk), .iRESET(iRESET), .iFRAME_BASE(iFRAME_BASE), .iLINE_STRIDE(iLINE_STRIDE),
        .iFRAME_START(iFRAME_START), .iLINE_REQ(iLINE_REQ), .oAV_ADDRESS(oAV_ADDRESS),
        .oAV_READ(oAV_READ), .oAV_BURSTCOUNT(oAV_BURSTCOUNT), .iAV_WAITREQUEST(iAV_WAITREQUEST),
        .iAV_READDATA(iAV_READDATA), .iAV_READDATAVALID(iAV_READDATAVALID), .oPIX_RGB(oPIX_RGB),
        .oPIX_WRITE(oPIX_WRITE), .oPIX_START(oPIX_START), .iPIX_FULL(iPIX_FULL), .oBUSY(oBUSY),
        .oFRAME_DONE(oFRAME_DONE), .oOVERRUN(oOVERRUN)
    );

    int passed = 0, total = 0;

    // Slave / sink observation state
    logic [AW-1:0] ret_q[$];
    logic [AW-1:0] burst_addr[$];
    int            burst_len[$];
    logic [14:0]   pix_q[$];
    int starts, start_with_write, full_writes, accepted, returned, hold_viol, first_req_cycles;
    int req_cycles = 0, stall_left = 0, ret_limit = 1 << 30;
    bit rand_stall = 0, rand_full = 0, full_force = 0, full_prev = 0;
    logic [AW-1:0] hold_addr, ret_a;
    logic [4:0]    hold_bc;

    function automatic logic [15:0] data_of(input logic [AW-1:0] a);
        logic [31:0] t;
        t = {10'd0, a} * 32'h9E37_79B1;
        return t[27:12];
    endfunction

    // Mismatching pixels against the expected line starting at word address row.
    function automatic int pix_errs(input logic [AW-1:0] row);
        logic [15:0] d;
        int e;
        e = 0;
        if (pix_q.size() != LP) return LP + 1;
        foreach (pix_q[k]) begin
            d = data_of(row + AW'(k));
            if (pix_q[k] !== d[14:0]) e++;
        end
        return e;
    endfunction

    // Line is split into chunks of at most BU words, issued in address order.
    function automatic int burst_errs(input logic [AW-1:0] row);
        int off, j, n, e;
        off = 0; j = 0; e = 0;
        while (off < LP) begin
            n = (LP - off > BU) ? BU : LP - off;
            if (j >= burst_addr.size()) e++;
            else if (burst_addr[j] !== row + AW'(off) || burst_len[j] != n) e++;
            off += n;
            j++;
        end
        if (burst_addr.size() != j) e++;
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        iPIX_FULL = full_force || (rand_full && ($urandom_range(0, 2) == 0));
    end

    always @(negedge clk) begin
        if (iRESET) begin
            ret_q.delete();
            iAV_READDATAVALID = 1'b0;
            iAV_WAITREQUEST = 1'b0;
            req_cycles = 0;
            stall_left = 0;
        end else begin
            iAV_READDATAVALID = 1'b0;
            if (ret_q.size() > 0 && returned < ret_limit && $urandom_range(0, 3) != 0) begin
                ret_a = ret_q.pop_front();
                iAV_READDATA = data_of(ret_a);
                iAV_READDATAVALID = 1'b1;
                returned++;
            end
            if (oAV_READ) begin
                req_cycles++;
                if (req_cycles == 1) begin
                    hold_addr = oAV_ADDRESS;
                    hold_bc = oAV_BURSTCOUNT;
                    if (rand_stall) stall_left = $urandom_range(0, 3);
                end else if (oAV_ADDRESS !== hold_addr || oAV_BURSTCOUNT !== hold_bc) begin
                    hold_viol++;
                end
                if (stall_left > 0) begin
                    iAV_WAITREQUEST = 1'b1;
                    stall_left--;
                end else begin
                    iAV_WAITREQUEST = 1'b0;
                    if (burst_addr.size() == 0) first_req_cycles = req_cycles;
                    burst_addr.push_back(oAV_ADDRESS);
                    burst_len.push_back(int'(oAV_BURSTCOUNT));
                    for (int i = 0; i < int'(oAV_BURSTCOUNT); i++)
                        ret_q.push_back(oAV_ADDRESS + AW'(i));
                    accepted += int'(oAV_BURSTCOUNT);
                    req_cycles = 0;
                end
            end else begin
                iAV_WAITREQUEST = 1'b0;
                req_cycles = 0;
            end
            if (oPIX_START) begin
                starts++;
                if (oPIX_WRITE) start_with_write++;
            end
            if (oPIX_WRITE) begin
                pix_q.push_back(oPIX_RGB);
                if (full_prev) full_writes++;
            end
            full_prev = iPIX_FULL;
        end
    end

    task automatic clear_logs();
        burst_addr.delete(); burst_len.delete(); pix_q.delete();
        starts = 0; start_with_write = 0; full_writes = 0; accepted = 0; returned = 0;
        hold_viol = 0; first_req_cycles = 0;
    endtask

    task automatic frame_start(input logic [AW-1:0] b, input logic [AW-1:0] s, input bit req);
        @(posedge clk); #1;
        iFRAME_BASE = b; iLINE_STRIDE = s; iFRAME_START = 1'b1; iLINE_REQ = req;
        @(posedge clk); #1;
        iFRAME_START = 1'b0; iLINE_REQ = 1'b0;
    endtask

    task automatic pulse_line_req();
        @(posedge clk); #1 iLINE_REQ = 1'b1;
        @(posedge clk); #1 iLINE_REQ = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!oBUSY) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        logic [63:0] outs;
        iRESET = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        outs = {oAV_ADDRESS, oAV_READ, oAV_BURSTCOUNT, oPIX_RGB, oPIX_WRITE, oPIX_START,
                oBUSY, oFRAME_DONE, oOVERRUN};
        total++;
        if (outs !== 64'd0) $display("FAIL reset_outputs: got %0h, want 0", outs);
        else passed++;
        @(posedge clk); #1 iRESET = 1'b0;
    endtask

    task automatic test_basic_line();
        bit ok;
        clear_logs();
        frame_start(22'h100, 22'd64, 0);
        pulse_line_req();
        wait_idle(ok);
        total++; if (!ok) $display("FAIL basic_done: got busy, want idle"); else passed++;
        total++;
        if (burst_errs(22'h100) != 0) $display("FAIL basic_bursts: got %0d bad, want 0",
                                               burst_errs(22'h100));
        else passed++;
        total++;
        if (burst_len.size() != 3 || burst_addr[2] !== 22'h120 || burst_len[2] != 8)
            $display("FAIL basic_last_burst: got %0d bursts, want 8 words at 0x120",
                     burst_len.size());
        else passed++;
        total++;
        if (starts != 1 || start_with_write != 0)
            $display("FAIL basic_sol: got %0d starts/%0d with write, want 1/0", starts,
                     start_with_write);
        else passed++;
        total++;
        if (pix_errs(22'h100) != 0) $display("FAIL basic_pixels: got %0d bad (n=%0d), want 0",
                                             pix_errs(22'h100), pix_q.size());
        else passed++;
    endtask

    task automatic test_frame_done();
        bit ok;
        clear_logs();
        pulse_line_req();
        wait_idle(ok);
        total++;
        if (!ok || burst_addr.size() == 0 || burst_addr[0] !== 22'h140)
            $display("FAIL line1_addr: got %0d bursts, want first at 0x140", burst_addr.size());
        else passed++;
        total++;
        if (pix_errs(22'h140) != 0) $display("FAIL line1_pixels: got %0d bad, want 0",
                                             pix_errs(22'h140));
        else passed++;
        total++;
        if (oFRAME_DONE !== 1'b0) $display("FAIL done_early: got %b, want 0", oFRAME_DONE);
        else passed++;
        clear_logs();
        pulse_line_req();
        wait_idle(ok);
        total++;
        if (pix_errs(22'h180) != 0) $display("FAIL line2_pixels: got %0d bad, want 0",
                                             pix_errs(22'h180));
        else passed++;
        total++;
        if (oFRAME_DONE !== 1'b1) $display("FAIL frame_done: got %b, want 1", oFRAME_DONE);
        else passed++;
        clear_logs();
        pulse_line_req();
        repeat (30) @(negedge clk);
        total++;
        if (burst_addr.size() != 0 || starts != 0 || oOVERRUN !== 1'b0)
            $display("FAIL req_after_done: got %0d reads, ovr %b, want 0 and 0",
                     burst_addr.size(), oOVERRUN);
        else passed++;
    endtask

    task automatic test_pix_full();
        bit ok;
        int buffered;
        logic [AW-1:0] base;
        base = AW'($urandom);
        clear_logs();
        frame_start(base, AW'($urandom_range(1, 4096)), 0);
        pulse_line_req();
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (pix_q.size() >= 2) begin ok = 1; break; end
        end
        full_force = 1;
        repeat (100) @(negedge clk);
        buffered = accepted - pix_q.size();
        full_force = 0;
        total++;
        if (full_writes != 0) $display("FAIL full_writes: got %0d, want 0", full_writes);
        else passed++;
        total++;
        if (!ok || buffered > 2 * BU)
            $display("FAIL full_buffered: got %0d words, want <= %0d", buffered, 2 * BU);
        else passed++;
        wait_idle(ok);
        total++;
        if (!ok || pix_errs(base) != 0) $display("FAIL full_pixels: got %0d bad, want 0",
                                                 pix_errs(base));
        else passed++;
    endtask

    task automatic test_waitreq();
        bit ok;
        logic [AW-1:0] base;
        base = AW'($urandom);
        clear_logs();
        frame_start(base, 22'd100, 0);
        stall_left = 5;
        pulse_line_req();
        wait_idle(ok);
        total++;
        if (first_req_cycles != 6 || hold_viol != 0)
            $display("FAIL wait_hold: got %0d cycles/%0d changes, want 6/0", first_req_cycles,
                     hold_viol);
        else passed++;
        total++;
        if (!ok || pix_errs(base) != 0) $display("FAIL wait_pixels: got %0d bad, want 0",
                                                 pix_errs(base));
        else passed++;
    endtask

    task automatic test_drain();
        bit ok;
        logic [AW-1:0] nb;
        nb = 22'h2A000;
        clear_logs();
        full_force = 1;
        ret_limit = 20;
        frame_start(22'h1000, 22'd64, 0);
        pulse_line_req();
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (returned == 20 && accepted == 32) begin ok = 1; break; end
        end
        repeat (5) @(negedge clk);
        total++;
        if (!ok || accepted - returned != 12)
            $display("FAIL drain_setup: got %0d outstanding, want 12", accepted - returned);
        else passed++;
        frame_start(nb, 22'd64, 0);
        ret_limit = 1 << 30;
        @(negedge clk);
        total++;
        if (oBUSY !== 1'b1) $display("FAIL drain_busy: got %b, want 1", oBUSY); else passed++;
        wait_idle(ok);
        full_force = 0;
        total++;
        if (!ok || returned != 32 || accepted != 32 || pix_q.size() != 0)
            $display("FAIL drain_flush: got ret %0d acc %0d writes %0d, want 32 32 0", returned,
                     accepted, pix_q.size());
        else passed++;
        clear_logs();
        pulse_line_req();
        wait_idle(ok);
        total++;
        if (!ok || burst_errs(nb) != 0 || pix_errs(nb) != 0)
            $display("FAIL drain_next_line: got %0d/%0d bad, want 0/0", burst_errs(nb),
                     pix_errs(nb));
        else passed++;
    endtask

    task automatic test_overrun_reset();
        bit ok;
        logic [63:0] outs;
        clear_logs();
        frame_start(22'h3000, 22'd64, 0);
        pulse_line_req();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (pix_q.size() >= 5) break;
        end
        pulse_line_req();
        @(negedge clk);
        total++;
        if (oOVERRUN !== 1'b1) $display("FAIL overrun_set: got %b, want 1", oOVERRUN);
        else passed++;
        wait_idle(ok);
        total++;
        if (!ok || oOVERRUN !== 1'b1 || pix_errs(22'h3000) != 0)
            $display("FAIL overrun_sticky: got ovr %b, %0d bad, want 1 and 0", oOVERRUN,
                     pix_errs(22'h3000));
        else passed++;
        frame_start(22'h3000, 22'd64, 0);
        @(negedge clk);
        total++;
        if (oOVERRUN !== 1'b0) $display("FAIL overrun_clear: got %b, want 0", oOVERRUN);
        else passed++;
        clear_logs();
        pulse_line_req();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (accepted > 0) break;
        end
        @(posedge clk); #1 iRESET = 1'b1;
        @(posedge clk);
        @(negedge clk);
        outs = {oAV_ADDRESS, oAV_READ, oAV_BURSTCOUNT, oPIX_RGB, oPIX_WRITE, oPIX_START,
                oBUSY, oFRAME_DONE, oOVERRUN};
        total++;
        if (outs !== 64'd0) $display("FAIL reset_mid_fetch: got %0h, want 0", outs);
        else passed++;
        @(posedge clk); #1 iRESET = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int e;
        logic [AW-1:0] base, stride, row;
        rand_full = 1;
        rand_stall = 1;
        for (int f = 0; f < 2; f++) begin
            base = AW'($urandom);
            stride = AW'($urandom);
            row = base;
            for (int l = 0; l < NL; l++) begin
                clear_logs();
                if (l == 0) frame_start(base, stride, 1);
                else pulse_line_req();
                wait_idle(ok);
                e = pix_errs(row) + burst_errs(row) + hold_viol + full_writes + (ok ? 0 : 1);
                total++;
                if (e != 0) $display("FAIL rand_line f%0d l%0d: got %0d errors, want 0", f, l, e);
                else passed++;
                row = row + stride;
            end
            total++;
            if (oFRAME_DONE !== 1'b1) $display("FAIL rand_frame_done: got %b, want 1", oFRAME_DONE);
            else passed++;
        end
        rand_full = 0;
        rand_stall = 0;
    endtask

    initial begin
        clear_logs();
        test_reset();
        test_basic_line();
        test_frame_done();
        test_pix_full();
        test_waitreq();
        test_drain();
        test_overrun_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
